// File: rtl/hit_response_ctrl_pkg.sv
// rtl/hit_response_ctrl_pkg.sv - shared game state encoding and sprite geometry
package hit_response_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_EXPLODE = 3'd2,
    ST_INVULN  = 3'd3,
    ST_OVER    = 3'd4
  } game_state_e;

  localparam int SPRITE_SIZE = 50;

  // Counter width shared by every frame-paced timer in the game.
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/hit_response_ctrl_frame_counter.sv
// rtl/hit_response_ctrl_frame_counter.sv - counts frame ticks up to a load value
// and pulses done on the tick that completes the count, then restarts from zero.
module hit_response_ctrl_frame_counter
  import hit_response_ctrl_pkg::*;
#(
  parameter int W = FRAME_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == load - W'(1)) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hit_response_ctrl.sv
// rtl/hit_response_ctrl.sv - turns collision edges into lives, enemy kill,
// explosion animation, invulnerability blink and game over.
module hit_response_ctrl
  import hit_response_ctrl_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int EXPLODE_STEPS = 8,
  parameter int STEP_FRAMES   = 4,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       collision,
  output logic [2:0] lives,
  output logic       mp_exist,
  output logic       mp_visible,
  output logic       ep_kill,
  output logic       exploding,
  output logic [2:0] explode_idx,
  output logic       game_over
);

  localparam int CW = FRAME_CNT_W;

  game_state_e state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic        mp_exist_q, mp_exist_d;
  logic        mp_visible_q, mp_visible_d;
  logic        ep_kill_q, ep_kill_d;
  logic        exploding_q, exploding_d;
  logic [2:0]  explode_idx_q, explode_idx_d;
  logic        game_over_q, game_over_d;
  logic        coll_q;

  logic hit_evt;
  logic step_clr, step_done;
  logic inv_clr, inv_done;
  logic blink_done;

  assign hit_evt = collision & ~coll_q;

  // Timers only run in their own state; leaving the state or restarting clears them.
  assign step_clr = game_start | (state_q != ST_EXPLODE);
  assign inv_clr  = game_start | (state_q != ST_INVULN);

  hit_response_ctrl_frame_counter #(.W(CW)) u_step_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (step_clr),
    .tick (frame_tick),
    .load (CW'(STEP_FRAMES)),
    .done (step_done)
  );

  hit_response_ctrl_frame_counter #(.W(CW)) u_inv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (inv_clr),
    .tick (frame_tick),
    .load (CW'(INVULN_FRAMES)),
    .done (inv_done)
  );

  hit_response_ctrl_frame_counter #(.W(CW)) u_blink_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (inv_clr),
    .tick (frame_tick),
    .load (CW'(BLINK_FRAMES)),
    .done (blink_done)
  );

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    mp_exist_d    = mp_exist_q;
    mp_visible_d  = mp_visible_q;
    ep_kill_d     = 1'b0;
    exploding_d   = exploding_q;
    explode_idx_d = explode_idx_q;
    game_over_d   = game_over_q;

    if (game_start) begin
      state_d       = ST_PLAY;
      lives_d       = 3'(LIVES);
      mp_exist_d    = 1'b1;
      mp_visible_d  = 1'b1;
      exploding_d   = 1'b0;
      explode_idx_d = 3'd0;
      game_over_d   = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (hit_evt) begin
            state_d       = ST_EXPLODE;
            lives_d       = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            ep_kill_d     = 1'b1;
            mp_exist_d    = 1'b0;
            mp_visible_d  = 1'b0;
            exploding_d   = 1'b1;
            explode_idx_d = 3'd0;
          end
        end
        ST_EXPLODE: begin
          if (step_done) begin
            if (explode_idx_q == 3'(EXPLODE_STEPS - 1)) begin
              exploding_d   = 1'b0;
              explode_idx_d = 3'd0;
              if (lives_q == 3'd0) begin
                state_d     = ST_OVER;
                game_over_d = 1'b1;
              end else begin
                state_d      = ST_INVULN;
                mp_exist_d   = 1'b1;
                mp_visible_d = 1'b1;
              end
            end else begin
              explode_idx_d = explode_idx_q + 3'd1;
            end
          end
        end
        ST_INVULN: begin
          mp_exist_d = 1'b1;
          if (inv_done) begin
            state_d      = ST_PLAY;
            mp_visible_d = 1'b1;
          end else if (blink_done) begin
            mp_visible_d = ~mp_visible_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lives_q       <= 3'd0;
      mp_exist_q    <= 1'b0;
      mp_visible_q  <= 1'b0;
      ep_kill_q     <= 1'b0;
      exploding_q   <= 1'b0;
      explode_idx_q <= 3'd0;
      game_over_q   <= 1'b0;
      coll_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      mp_exist_q    <= mp_exist_d;
      mp_visible_q  <= mp_visible_d;
      ep_kill_q     <= ep_kill_d;
      exploding_q   <= exploding_d;
      explode_idx_q <= explode_idx_d;
      game_over_q   <= game_over_d;
      coll_q        <= collision;
    end
  end

  assign lives       = lives_q;
  assign mp_exist    = mp_exist_q;
  assign mp_visible  = mp_visible_q;
  assign ep_kill     = ep_kill_q;
  assign exploding   = exploding_q;
  assign explode_idx = explode_idx_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_hit_response_ctrl.sv
// tb/tb_hit_response_ctrl.sv - scoreboard bench: expected output changes queued
// by the stimulus, popped by a monitor whenever the DUT outputs change.
module tb_hit_response_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick = 1'b0;
  logic       game_start = 1'b0;
  logic       collision  = 1'b0;
  logic [2:0] lives;
  logic       mp_exist;
  logic       mp_visible;
  logic       ep_kill;
  logic       exploding;
  logic [2:0] explode_idx;
  logic       game_over;

  hit_response_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .game_start  (game_start),
    .collision   (collision),
    .lives       (lives),
    .mp_exist    (mp_exist),
    .mp_visible  (mp_visible),
    .ep_kill     (ep_kill),
    .exploding   (exploding),
    .explode_idx (explode_idx),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] v;
    int          tk;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          ticks_sent = 0;
  int          base_tk    = 0;
  logic        mon_en     = 1'b0;
  logic [10:0] prev       = '0;

  function automatic logic [10:0] mk(input logic [2:0] l, input logic ex, input logic vis,
                                     input logic kill, input logic expl,
                                     input logic [2:0] idx, input logic go);
    return {l, ex, vis, kill, expl, idx, go};
  endfunction

  function automatic logic [10:0] dut_snap();
    return {lives, mp_exist, mp_visible, ep_kill, exploding, explode_idx, game_over};
  endfunction

  task automatic push(input logic [10:0] v, input int tk);
    exp_t e;
    e.v  = v;
    e.tk = tk;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each call is one clock: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic cyc(input logic tk, input logic st, input logic co);
    @(negedge clk);
    frame_tick = tk;
    game_start = st;
    collision  = co;
    if (tk) ticks_sent++;
    @(posedge clk);
    #2;
  endtask

  task automatic run_ticks(input int n, input logic co);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, co);
      cyc(1'b1, 1'b0, co);
    end
  endtask

  // Hit in PLAY: kill pulse, then explode_idx steps every 4 ticks up to nidx.
  task automatic push_explode(input logic [2:0] l_before, input int nidx);
    logic [2:0] l;
    l = (l_before == 3'd0) ? 3'd0 : l_before - 3'd1;
    base_tk = ticks_sent;
    push(mk(l, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0), base_tk);
    push(mk(l, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0), base_tk);
    for (int k = 1; k <= nidx; k++)
      push(mk(l, 1'b0, 1'b0, 1'b0, 1'b1, 3'(k), 1'b0), base_tk + 4 * k);
  endtask

  // End of explosion at +32 ticks; then either OVER, or INVULN blinking every 8 ticks until +92.
  task automatic push_finish(input logic [2:0] l);
    if (l == 3'd0) begin
      push(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1), base_tk + 32);
    end else begin
      push(mk(l, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), base_tk + 32);
      for (int j = 1; j <= 7; j++)
        push(mk(l, 1'b1, (j % 2) == 0, 1'b0, 1'b0, 3'd0, 1'b0), base_tk + 32 + 8 * j);
      push(mk(l, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), base_tk + 92);
    end
  endtask

  always @(posedge clk) begin
    logic [10:0] cur;
    exp_t        e;
    #1;
    if (mon_en) begin
      cur = dut_snap();
      if (cur !== prev) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change: got %h previous %h at tick %0d", cur, prev, ticks_sent);
        end else begin
          e = sb.pop_front();
          if (cur !== e.v || (e.tk >= 0 && e.tk != ticks_sent)) begin
            mismatched++;
            $display("FAIL output_change: got %h at tick %0d expected %h at tick %0d",
                     cur, ticks_sent, e.v, e.tk);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    #12;
    chk("reset_state", dut_snap(), 11'd0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Collision edges in IDLE must not change anything.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    push(mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), -1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("start_state", dut_snap(), mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0);

    // First hit, collision level held for 100 cycles.
    push_explode(3'd3, 7);
    push_finish(3'd2);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b1);
    run_ticks(32, 1'b1);
    chk("invuln_entry", dut_snap(), mk(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // Fresh edges during INVULN are ignored.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    run_ticks(60, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);

    // Drop and re-raise: second hit.
    cyc(1'b0, 1'b0, 1'b0);
    push_explode(3'd2, 7);
    push_finish(3'd1);
    cyc(1'b0, 1'b0, 1'b1);
    run_ticks(92, 1'b1);

    // Third hit: game over.
    cyc(1'b0, 1'b0, 1'b0);
    push_explode(3'd1, 7);
    push_finish(3'd0);
    cyc(1'b0, 1'b0, 1'b1);
    run_ticks(32, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("over_state", dut_snap(), mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));

    push(mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), -1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_from_over", dut_snap(), mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // Restart and collision edge in the same cycle: restart wins.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("start_beats_hit", dut_snap(), mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0);

    // Async reset in the middle of the explosion at explode_idx 5.
    push_explode(3'd3, 5);
    cyc(1'b0, 1'b0, 1'b1);
    run_ticks(21, 1'b0);
    chk("explode_idx5", dut_snap(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0));
    push(11'd0, -1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset", dut_snap(), 11'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    push(mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0), -1);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("post_reset_start", dut_snap(), mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
    chk("scoreboard_drained", 11'(sb.size()), 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
